// File: rtl/obuf_drain_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// obuf_drain_pkg : shared sizes of the output buffer and drain FSM encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
package obuf_drain_pkg;

   localparam int c_vec_width = 64;
   localparam int c_arr_depth = 64;
   localparam int c_addr_w    = 6;

   typedef logic [1:0] state_t;

   localparam state_t c_st_idle  = 2'd0;
   localparam state_t c_st_run   = 2'd1;
   localparam state_t c_st_flush = 2'd2;
   localparam state_t c_st_done  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/skid_fifo2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// skid_fifo2 : 2-entry FIFO with registered head, push/pop may coincide
// Revision: 1.0
// ---------------------------------------------------------------------------
module skid_fifo2 #(
   parameter int WIDTH = 64
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic [1:0]       o_occ
);

   logic [WIDTH-1:0] r_head;
   logic [WIDTH-1:0] r_tail;
   logic [1:0]       r_occ;
   logic             w_pop;
   logic             w_push;

   assign w_pop  = i_pop & (r_occ != 2'd0);
   // A push into a full FIFO is only legal when a pop frees a slot this cycle.
   assign w_push = i_push & ((r_occ != 2'd2) | w_pop);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_head <= '0;
         r_tail <= '0;
         r_occ  <= 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_occ == 2'd0) r_head <= i_din;
               else               r_tail <= i_din;
               r_occ <= r_occ + 2'd1;
            end
            2'b01: begin
               r_head <= r_tail;
               r_occ  <= r_occ - 2'd1;
            end
            2'b11: begin
               if (r_occ == 2'd1) begin
                  r_head <= i_din;
               end else begin
                  r_head <= r_tail;
                  r_tail <= i_din;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_head = r_head;
   assign o_occ  = r_occ;

endmodule
`default_nettype wire

// File: rtl/obuf_drain.sv
`default_nettype none
// ---------------------------------------------------------------------------
// obuf_drain : streams buffered columns out of the output RAM over valid/ready
// Revision: 1.0
// ---------------------------------------------------------------------------
module obuf_drain
   import obuf_drain_pkg::*;
#(
   parameter int VEC_WIDTH = c_vec_width,
   parameter int ARR_DEPTH = c_arr_depth,
   parameter int ADDR_W    = c_addr_w
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   input  logic [ADDR_W:0]      i_len,
   output logic                 o_busy,
   output logic                 o_ram_re,
   output logic [ADDR_W-1:0]    o_ram_addr,
   input  logic [VEC_WIDTH-1:0] i_ram_data,
   output logic [VEC_WIDTH-1:0] o_data,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic                 o_last,
   output logic                 o_done
);

   localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(ARR_DEPTH);
   localparam logic [ADDR_W:0] c_one   = (ADDR_W+1)'(1);

   state_t          r_state;
   state_t          w_next;
   logic [ADDR_W:0] r_len;
   logic [ADDR_W:0] r_rd_cnt;
   logic [ADDR_W:0] r_beat_cnt;
   logic            r_inflight;
   logic [ADDR_W:0] w_len_eff;
   logic [ADDR_W:0] w_len_m1;
   logic [1:0]      w_occ;
   logic [2:0]      w_level;
   logic            w_pop;
   logic            w_re;

   assign w_len_eff = ((i_len == '0) || (i_len > c_depth)) ? c_depth : i_len;
   assign w_len_m1  = r_len - c_one;
   assign o_valid   = (w_occ != 2'd0);
   assign w_pop     = o_valid & i_ready;
   // Entries the FIFO will hold once the outstanding read lands and this cycle's pop leaves.
   assign w_level   = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= c_st_idle;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_st_idle:  if (i_start) w_next = c_st_run;
         c_st_run:   if (w_re && (r_rd_cnt == w_len_m1)) w_next = c_st_flush;
         c_st_flush: if (!r_inflight && ((w_occ == 2'd0) || ((w_occ == 2'd1) && w_pop)))
                        w_next = c_st_done;
         default:    w_next = c_st_idle;
      endcase
   end

   always_comb begin
      o_busy = (r_state != c_st_idle);
      w_re   = (r_state == c_st_run) && (w_level < 3'd2);
      o_done = (r_state == c_st_done);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_len      <= '0;
         r_rd_cnt   <= '0;
         r_beat_cnt <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_re;
         if ((r_state == c_st_idle) && i_start) begin
            r_len      <= w_len_eff;
            r_rd_cnt   <= '0;
            r_beat_cnt <= '0;
         end else begin
            if (w_re)  r_rd_cnt   <= r_rd_cnt + c_one;
            if (w_pop) r_beat_cnt <= r_beat_cnt + c_one;
         end
      end
   end

   assign o_ram_re   = w_re;
   assign o_ram_addr = r_rd_cnt[ADDR_W-1:0];
   assign o_last     = o_valid & (r_beat_cnt == w_len_m1);

   skid_fifo2 #(
      .WIDTH (VEC_WIDTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (r_inflight),
      .i_din   (i_ram_data),
      .i_pop   (w_pop),
      .o_head  (o_data),
      .o_occ   (w_occ)
   );

endmodule
`default_nettype wire

// File: tb/tb_obuf_drain.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_obuf_drain : table-driven drains with a scoreboard of expected columns
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_obuf_drain;
   import obuf_drain_pkg::*;

   localparam int VW = 64;
   localparam int AD = 64;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW:0]   len = '0;
   logic          busy;
   logic          ram_re;
   logic [AW-1:0] ram_addr;
   logic [VW-1:0] ram_q = '0;
   logic [VW-1:0] data;
   logic          valid;
   logic          ready = 1'b0;
   logic          last;
   logic          done;

   always #5 clk = ~clk;

   obuf_drain dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_start    (start),
      .i_len      (len),
      .o_busy     (busy),
      .o_ram_re   (ram_re),
      .o_ram_addr (ram_addr),
      .i_ram_data (ram_q),
      .o_data     (data),
      .o_valid    (valid),
      .i_ready    (ready),
      .o_last     (last),
      .o_done     (done)
   );

   // Column k holds {16{k[3:0]}}, top bits flipped by k[5:4] so all 64 columns differ.
   function automatic logic [VW-1:0] dat(input int k);
      logic [5:0] a;
      a = k[5:0];
      return {16{a[3:0]}} ^ {a[5:4], 62'd0};
   endfunction

   always @(posedge clk) if (ram_re) ram_q <= dat(int'(ram_addr));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   logic [VW-1:0] sb[$];
   bit            mon_en = 1'b0;
   bit            hold_pend = 1'b0;
   logic [VW-1:0] hold_val = '0;
   int cur_mode = 0, start_cyc = 0, beats = 0, done_cyc = -1, first_cyc = -1;
   int prev_beat = -1, re_stall = 0, re_idx = 0;

   always @(negedge clk) begin : mon
      int rel;
      if (mon_en) begin
         rel = cyc - start_cyc;
         if (ram_re) begin
            chk("ram_addr", 64'(ram_addr), 64'(re_idx[AW-1:0]));
            re_idx++;
            if (cur_mode == 2 && !ready) re_stall++;
         end
         if (hold_pend && valid) chk("stall_hold", data, hold_val);
         hold_pend = valid && !ready;
         hold_val  = data;
         if (valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_beat: got valid beat %0h expected none", data);
            end else begin
               chk("last", 64'(last), 64'(sb.size() == 1));
               if (ready) begin
                  chk("data", data, sb.pop_front());
                  beats++;
                  if (beats == 1) first_cyc = rel;
                  if (cur_mode == 2 && prev_beat >= 0) chk("consecutive", 64'(rel - prev_beat), 64'd1);
                  prev_beat = rel;
               end
            end
         end
         if (done) done_cyc = rel;
      end
   end

   task automatic drive_ready(input int k);
      case (cur_mode)
         0:       ready = 1'b1;
         1:       ready = (k % 2 == 0);
         default: ready = (k >= 13);
      endcase
   endtask

   task automatic run_drain(input logic [AW:0] l, input int mode, input bit retrig,
                            input int exp_beats, input int exp_done);
      int eff;
      bit rt_sent;
      bit fin;
      eff = (l == 0 || l > AD) ? AD : int'(l);
      sb.delete();
      for (int k = 0; k < eff; k++) sb.push_back(dat(k));
      cur_mode = mode; beats = 0; done_cyc = -1; first_cyc = -1; prev_beat = -1;
      re_stall = 0; re_idx = 0; hold_pend = 1'b0; rt_sent = 1'b0; fin = 1'b0;
      @(posedge clk); #1;
      start_cyc = cyc; start = 1'b1; len = l; drive_ready(0); mon_en = 1'b1;
      for (int k = 1; k < 400 && !fin; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (retrig && !rt_sent && beats == 10) begin
            start = 1'b1;
            rt_sent = 1'b1;
         end
         drive_ready(k);
         if (k == 1) chk("busy_after_start", 64'(busy), 64'd1);
         if (done_cyc >= 0) begin
            chk("busy_after_done", 64'(busy), 64'd0);
            fin = 1'b1;
         end
      end
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL timeout: got no o_done expected o_done within 400 cycles (len %0d)", l);
      end
      start = 1'b0;
      chk("beat_count", 64'(beats), 64'(exp_beats));
      chk("done_cycle", 64'(done_cyc), 64'(exp_done));
      chk("reads_issued", 64'(re_idx), 64'(eff));
      chk("sb_empty", 64'(sb.size()), 64'd0);
      if (mode == 0) chk("first_valid_cycle", 64'(first_cyc), 64'd3);
      if (mode == 2) chk("reads_during_stall", 64'(re_stall), 64'd2);
   endtask

   typedef struct {
      logic [AW:0] len;
      int          mode;      // 0 always ready, 1 alternating, 2 stalled until cycle 13
      bit          retrig;
      int          exp_beats;
      int          exp_done;
   } vec_t;

   vec_t vecs[6];

   initial begin : main
      bit seen;
      vecs[0] = '{7'd64,  0, 1'b0, 64, 67};
      vecs[1] = '{7'd5,   1, 1'b0, 5,  13};
      vecs[2] = '{7'd3,   2, 1'b0, 3,  16};
      vecs[3] = '{7'd0,   0, 1'b1, 64, 67};
      vecs[4] = '{7'd1,   0, 1'b0, 1,  4};
      vecs[5] = '{7'd100, 0, 1'b0, 64, 67};

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_data", data, 64'd0);
      chk("reset_ctrl", 64'({busy, ram_re, ram_addr, valid, last, done}), 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++)
         run_drain(vecs[i].len, vecs[i].mode, vecs[i].retrig, vecs[i].exp_beats, vecs[i].exp_done);

      // Reset in the middle of a full-length drain, then a short drain afterwards.
      sb.delete();
      for (int k = 0; k < AD; k++) sb.push_back(dat(k));
      cur_mode = 0; beats = 0; re_idx = 0; done_cyc = -1; prev_beat = -1; hold_pend = 1'b0;
      @(posedge clk); #1;
      start_cyc = cyc; start = 1'b1; len = 7'd64; ready = 1'b1; mon_en = 1'b1;
      for (int k = 0; k < 100 && beats < 20; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      chk("beats_before_reset", 64'(beats), 64'd20);
      mon_en = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midreset_data", data, 64'd0);
      chk("midreset_ctrl", 64'({busy, ram_re, ram_addr, valid, last, done}), 64'd0);
      chk("midreset_state", 64'(dut.r_state), 64'(c_st_idle));
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (done || valid || busy) seen = 1'b1;
      end
      chk("quiet_after_reset", 64'(seen), 64'd0);
      run_drain(7'd2, 0, 1'b0, 2, 5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
